serial_adder: RTL and testbench

- Bit-serial adder stage built around the single-bit full adder `fa`, which has ports a, b, cin, sum and cout.
- Accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake.
- Feeds one operand bit pair per clock into `fa`, LSB first, and registers cout back as the next cin.
- Presents the WIDTH-bit sum and final carry-out through a valid/ready output handshake.

---
 rtl/serial_adder.sv | 133 +++++++++++++
 tb/tb_serial_adder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder bit per clock, LSB first, valid/ready on both sides.
// Optional signed-overflow output out_ovf when SERIAL_ADDER_OVF_EN is defined.

module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             out_ovf,
`endif
    output logic             out_cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             fa_sum, fa_cout;

    fa u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_d = fa_sum;
        end else begin : g_wn
            assign sum_d = {fa_sum, sum_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = S_RUN;
            S_RUN:  if (cnt_q == LAST) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand, sum and carry datapath; only moves while RUN or on load.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        carry_q <= in_cin;
                        cnt_q   <= '0;
                    end
                end
                S_RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    sum_q   <= sum_d;
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = carry_q;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // In the last RUN cycle carry_q is the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == S_RUN && cnt_q == LAST) begin
            ovf_q <= carry_q ^ fa_cout;
        end
    end

    assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder: WIDTH=8 instance plus a WIDTH=1 instance.
// Overflow checks are compiled in when SERIAL_ADDER_OVF_EN is defined.

module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       v8_in, r8_in, v8_out, r8_out, cin8, cout8;
    logic [7:0] a8, b8, s8;
    logic       v1_in, r1_in, v1_out, r1_out, cin1, cout1;
    logic [0:0] a1, b1, s1;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.WIDTH(8)) u8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v8_in),
        .in_ready  (r8_in),
        .in_a      (a8),
        .in_b      (b8),
        .in_cin    (cin8),
        .out_valid (v8_out),
        .out_ready (r8_out),
        .out_sum   (s8),
`ifdef SERIAL_ADDER_OVF_EN
        .out_ovf   (ovf8),
`endif
        .out_cout  (cout8)
    );

    serial_adder #(.WIDTH(1)) u1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1_in),
        .in_ready  (r1_in),
        .in_a      (a1),
        .in_b      (b1),
        .in_cin    (cin1),
        .out_valid (v1_out),
        .out_ready (r1_out),
        .out_sum   (s1),
`ifdef SERIAL_ADDER_OVF_EN
        .out_ovf   (ovf1),
`endif
        .out_cout  (cout1)
    );

    // Issue one WIDTH=8 operation and wait (bounded) for its result.
    // Leaves the DUT in DONE with out_ready low.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                          input logic c, output int lat);
        a8 = a; b8 = b; cin8 = c; v8_in = 1'b1;
        @(posedge clk); #1;
        v8_in = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        lat = 0;
        while (!v8_out && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release8();
        r8_out = 1'b1;
        @(posedge clk); #1;
        r8_out = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (r8_in !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got=%b exp=1", r8_in);
        end
        n_checks++;
        if (v8_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got=%b exp=0", v8_out);
        end
        n_checks++;
        if (s8 !== 8'h00) begin
            n_fail++; $display("FAIL reset_out_sum got=%h exp=00", s8);
        end
        n_checks++;
        if (cout8 !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_cout got=%b exp=0", cout8);
        end
        n_checks++;
        if (r1_in !== 1'b1 || v1_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_w1 got ready=%b valid=%b exp ready=1 valid=0",
                     r1_in, v1_out);
        end
`ifdef SERIAL_ADDER_OVF_EN
        n_checks++;
        if (ovf8 !== 1'b0) begin
            n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf8);
        end
`endif
    endtask

    task automatic test_add();
        logic [7:0] ta [3] = '{8'h5A, 8'hFF, 8'hFF};
        logic [7:0] tb [3] = '{8'h3C, 8'h01, 8'hFF};
        logic       tc [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] es [3] = '{8'h96, 8'h00, 8'hFF};
        logic       ec [3] = '{1'b0, 1'b1, 1'b1};
        int lat;
        for (int i = 0; i < 3; i++) begin
            issue8(ta[i], tb[i], tc[i], lat);
            n_checks++;
            if (lat !== 8) begin
                n_fail++; $display("FAIL add%0d_latency got=%0d exp=8", i, lat);
            end
            n_checks++;
            if (s8 !== es[i]) begin
                n_fail++; $display("FAIL add%0d_sum got=%h exp=%h", i, s8, es[i]);
            end
            n_checks++;
            if (cout8 !== ec[i]) begin
                n_fail++; $display("FAIL add%0d_cout got=%b exp=%b", i, cout8, ec[i]);
            end
            release8();
        end
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        logic [7:0] ta [3] = '{8'h7F, 8'h80, 8'h10};
        logic [7:0] tb [3] = '{8'h01, 8'h80, 8'h20};
        logic [7:0] es [3] = '{8'h80, 8'h00, 8'h30};
        logic       ec [3] = '{1'b0, 1'b1, 1'b0};
        logic       eo [3] = '{1'b1, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 3; i++) begin
            issue8(ta[i], tb[i], 1'b0, lat);
            n_checks++;
            if (s8 !== es[i] || cout8 !== ec[i] || ovf8 !== eo[i]) begin
                n_fail++;
                $display("FAIL ovf%0d got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                         i, s8, cout8, ovf8, es[i], ec[i], eo[i]);
            end
            release8();
        end
    endtask
`endif

    task automatic test_backpressure();
        int lat;
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; v8_in = 1'b1;
        @(posedge clk); #1;
        // keep in_valid high with junk operands through RUN
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        lat = 0;
        while (!v8_out && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== 8 || s8 !== 8'h46 || cout8 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_run_ignore got lat=%0d sum=%h cout=%b exp lat=8 sum=46 cout=0",
                     lat, s8, cout8);
        end
        for (int i = 0; i < 5; i++) begin
            v8_in = i[0];
            @(posedge clk); #1;
            n_checks++;
            if (v8_out !== 1'b1 || s8 !== 8'h46 || r8_in !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d got valid=%b sum=%h ready=%b exp valid=1 sum=46 ready=0",
                         i, v8_out, s8, r8_in);
            end
        end
        v8_in = 1'b1;
        r8_out = 1'b1;
        @(posedge clk); #1;
        v8_in = 1'b0; r8_out = 1'b0;
        n_checks++;
        if (v8_out !== 1'b0 || r8_in !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1",
                     v8_out, r8_in);
        end
        @(posedge clk); #1;
        n_checks++;
        if (r8_in !== 1'b1) begin
            n_fail++; $display("FAIL bp_no_accept got ready=%b exp=1", r8_in);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; v8_in = 1'b1;
        @(posedge clk); #1;
        v8_in = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (r8_in !== 1'b1 || v8_out !== 1'b0 || s8 !== 8'h00 || cout8 !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst got ready=%b valid=%b sum=%h cout=%b exp ready=1 valid=0 sum=00 cout=0",
                     r8_in, v8_out, s8, cout8);
        end
        issue8(8'h01, 8'h01, 1'b0, lat);
        n_checks++;
        if (lat !== 8 || s8 !== 8'h02 || cout8 !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_after got lat=%0d sum=%h cout=%b exp lat=8 sum=02 cout=0",
                     lat, s8, cout8);
        end
        release8();
    endtask

    task automatic test_w1();
        logic [2:0] v;
        logic [1:0] exp;
        int lat;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; v1_in = 1'b1;
            @(posedge clk); #1;
            v1_in = 1'b0;
            lat = 0;
            while (!v1_out && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            n_checks++;
            if (lat !== 1 || {cout1, s1} !== exp) begin
                n_fail++;
                $display("FAIL w1_%0d got lat=%0d res=%b exp lat=1 res=%b",
                         i, lat, {cout1, s1}, exp);
            end
            r1_out = 1'b1;
            @(posedge clk); #1;
            r1_out = 1'b0;
        end
    endtask

    initial begin
        v8_in = 1'b0; r8_out = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        v1_in = 1'b0; r1_out = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        test_reset();
        test_add();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        test_backpressure();
        test_reset_mid();
        test_w1();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
